// File: rtl/shot_resolver.sv
// Resolves player shots against the board memory and sweeps the board clear.
// Reads the target cell, classifies the shot, writes the new cell state back.
module shot_resolver #(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int SHIP_CELLS   = 20
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 shot_valid,
  output logic                                 shot_ready,
  input  logic [X_ADDR_WIDTH-1:0]              shot_x,
  input  logic [Y_ADDR_WIDTH-1:0]              shot_y,
  input  logic                                 clear_req,
  output logic                                 result_valid,
  output logic [1:0]                           result_code,
  output logic                                 clear_done,
  output logic                                 busy,
  output logic [7:0]                           hit_count,
  output logic                                 all_sunk,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0]                mem_read_data,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  output logic                                 mem_write_enable
);

  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic [DATA_WIDTH-1:0] CELL_EMPTY = DATA_WIDTH'(2'd0);
  localparam logic [DATA_WIDTH-1:0] CELL_SHIP  = DATA_WIDTH'(2'd1);
  localparam logic [DATA_WIDTH-1:0] CELL_MISS  = DATA_WIDTH'(2'd2);
  localparam logic [DATA_WIDTH-1:0] CELL_HIT   = DATA_WIDTH'(2'd3);

  localparam logic [1:0] RES_MISS    = 2'd0;
  localparam logic [1:0] RES_HIT     = 2'd1;
  localparam logic [1:0] RES_REPEAT  = 2'd2;
  localparam logic [1:0] RES_INVALID = 2'd3;

  localparam logic [X_ADDR_WIDTH:0]   X_LIM  = (X_ADDR_WIDTH+1)'(X_SIZE);
  localparam logic [Y_ADDR_WIDTH:0]   Y_LIM  = (Y_ADDR_WIDTH+1)'(Y_SIZE);
  localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);
  localparam logic [7:0]              SUNK_COUNT = 8'(SHIP_CELLS);

  logic [1:0]              state_r;
  logic                    shot_invalid_s;
  logic [X_ADDR_WIDTH-1:0] wr_x_s;
  logic [Y_ADDR_WIDTH-1:0] wr_y_s;
  logic                    clr_last_s;
  logic [AW-1:0]           clr_next_addr_s;

  assign shot_ready     = (state_r == ST_IDLE);
  assign busy           = (state_r != ST_IDLE);
  assign all_sunk       = (hit_count == SUNK_COUNT);
  assign shot_invalid_s = ({1'b0, shot_x} >= X_LIM) || ({1'b0, shot_y} >= Y_LIM);
  assign wr_x_s         = mem_write_addr[AW-1:Y_ADDR_WIDTH];
  assign wr_y_s         = mem_write_addr[Y_ADDR_WIDTH-1:0];
  assign clr_last_s     = (mem_write_addr == {X_LAST, Y_LAST});

  // Clear sweep address: y is the inner index, x advances when y wraps.
  always_comb begin
    clr_next_addr_s = mem_write_addr;
    if (wr_y_s == Y_LAST) begin
      clr_next_addr_s = {wr_x_s + X_ADDR_WIDTH'(1), {Y_ADDR_WIDTH{1'b0}}};
    end else begin
      clr_next_addr_s = {wr_x_s, wr_y_s + Y_ADDR_WIDTH'(1)};
    end
  end

  // Controller state, registered strobes, memory ports and hit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      result_valid     <= 1'b0;
      result_code      <= RES_MISS;
      clear_done       <= 1'b0;
      hit_count        <= 8'd0;
      mem_read_addr    <= {AW{1'b0}};
      mem_write_addr   <= {AW{1'b0}};
      mem_write_data   <= CELL_EMPTY;
      mem_write_enable <= 1'b0;
    end else begin
      result_valid     <= 1'b0;
      clear_done       <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clear_req) begin
            state_r          <= ST_CLEAR;
            hit_count        <= 8'd0;
            mem_write_enable <= 1'b1;
            mem_write_addr   <= {AW{1'b0}};
            mem_write_data   <= CELL_EMPTY;
          end else if (shot_valid) begin
            if (shot_invalid_s) begin
              result_valid <= 1'b1;
              result_code  <= RES_INVALID;
            end else begin
              mem_read_addr <= {shot_x, shot_y};
              state_r       <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_r <= ST_EVAL;
        end
        ST_EVAL: begin
          state_r        <= ST_IDLE;
          result_valid   <= 1'b1;
          mem_write_addr <= mem_read_addr;
          case (mem_read_data)
            CELL_SHIP: begin
              result_code      <= RES_HIT;
              mem_write_data   <= CELL_HIT;
              mem_write_enable <= 1'b1;
              if (hit_count != 8'hFF) begin
                hit_count <= hit_count + 8'd1;
              end
            end
            CELL_EMPTY: begin
              result_code      <= RES_MISS;
              mem_write_data   <= CELL_MISS;
              mem_write_enable <= 1'b1;
            end
            default: begin
              result_code <= RES_REPEAT;
            end
          endcase
        end
        ST_CLEAR: begin
          // The last write is already on the port; finish without another strobe.
          if (clr_last_s) begin
            state_r    <= ST_IDLE;
            clear_done <= 1'b1;
          end else begin
            mem_write_enable <= 1'b1;
            mem_write_addr   <= clr_next_addr_s;
            mem_write_data   <= CELL_EMPTY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: board memory model plus a
// rule-level reference board that predicts each shot outcome.
module tb_shot_resolver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       shot_valid = 1'b0;
  logic       clear_req = 1'b0;
  logic [3:0] shot_x = 4'd0;
  logic [3:0] shot_y = 4'd0;
  logic       shot_ready, result_valid, clear_done, busy, all_sunk, mem_write_enable;
  logic [1:0] result_code, mem_write_data;
  logic [1:0] mem_read_data;
  logic [7:0] hit_count, mem_read_addr, mem_write_addr;

  logic [1:0] mem [0:255];
  logic [1:0] ref_board [0:255];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [1:0] pl_data = 2'd0;
  int         exp_hits = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  shot_resolver dut (
    .clk(clk), .rst_n(rst_n), .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_x(shot_x), .shot_y(shot_y), .clear_req(clear_req),
    .result_valid(result_valid), .result_code(result_code), .clear_done(clear_done),
    .busy(busy), .hit_count(hit_count), .all_sunk(all_sunk),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  // Board memory: synchronous write, one-cycle registered read, bench preload port.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
    else if (pl_en) mem[pl_addr] <= pl_data;
    mem_read_data <= mem[mem_read_addr];
  end

  task automatic place(input logic [7:0] a, input logic [1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_board[a] = v;
  endtask

  // Reference rules: 0 EMPTY,1 SHIP,2 MISS,3 HIT -> result code, latency, write.
  task automatic model_shot(input logic [3:0] x, input logic [3:0] y, output logic [1:0] code,
                            output int elat, output int enwr, output logic [1:0] ewd);
    enwr = 0; ewd = 2'd0; elat = 3;
    if (x >= 4'd12 || y >= 4'd12) begin
      code = 2'd3; elat = 1;
    end else if (ref_board[{x, y}] == 2'd1) begin
      code = 2'd1; enwr = 1; ewd = 2'd3; ref_board[{x, y}] = 2'd3;
      if (exp_hits < 255) exp_hits++;
    end else if (ref_board[{x, y}] == 2'd0) begin
      code = 2'd0; enwr = 1; ewd = 2'd2; ref_board[{x, y}] = 2'd2;
    end else begin
      code = 2'd2;
    end
  endtask

  task automatic fire(input logic [3:0] x, input logic [3:0] y, output logic [1:0] code,
                      output int lat, output int nres, output int nwr, output logic [7:0] wa,
                      output logic [1:0] wd, output logic [7:0] ra1, output logic rdy1,
                      output logic [7:0] hc, output logic sunk, output logic rdy_res);
    shot_valid = 1'b1; shot_x = x; shot_y = y;
    @(posedge clk); #1;
    shot_valid = 1'b0; shot_x = 4'($urandom); shot_y = 4'($urandom);
    code = 2'd0; lat = 0; nres = 0; nwr = 0; wa = 8'd0; wd = 2'd0;
    hc = 8'd0; sunk = 1'b0; rdy_res = 1'b0;
    ra1 = mem_read_addr; rdy1 = shot_ready;
    for (int i = 1; i <= 4; i++) begin
      if (mem_write_enable) begin nwr++; wa = mem_write_addr; wd = mem_write_data; end
      if (result_valid) begin
        nres++;
        if (lat == 0) begin
          lat = i; code = result_code; hc = hit_count; sunk = all_sunk; rdy_res = shot_ready;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_clear(input logic with_shot, input int abort_at, output int nwr,
                           output int nbad, output int done_cyc, output int ndone, output int nres);
    logic [7:0] ea;
    clear_req = 1'b1;
    if (with_shot) begin shot_valid = 1'b1; shot_x = 4'd2; shot_y = 4'd2; end
    @(posedge clk); #1;
    clear_req = 1'b0; shot_valid = 1'b0;
    nwr = 0; nbad = 0; done_cyc = 0; ndone = 0; nres = 0;
    for (int i = 1; i <= 150; i++) begin
      if (mem_write_enable) begin
        ea = {4'(nwr / 12), 4'(nwr % 12)};
        if (mem_write_addr !== ea || mem_write_data !== 2'd0) nbad++;
        nwr++;
      end
      if (clear_done) begin ndone++; done_cyc = i; end
      if (result_valid) nres++;
      // Requests arriving mid-clear must be dropped.
      shot_valid = (i == 10); clear_req = (i == 10); shot_x = 4'd1; shot_y = 4'd1;
      if (i == abort_at) rst_n = 1'b0;
      @(posedge clk); #1;
      if (i == abort_at) break;
    end
    shot_valid = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({result_valid, result_code, clear_done, mem_write_enable, mem_write_addr, mem_write_data,
         mem_read_addr, hit_count, busy, all_sunk, shot_ready} !== {30'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b busy=%b rv=%b wen=%b hc=%0d", shot_ready, busy,
               result_valid, mem_write_enable, hit_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    int nwr, nbad, dc, nd, nres, nz;
    for (int a = 0; a < 144; a++) place({4'(a / 12), 4'(a % 12)}, 2'($urandom_range(3, 1)));
    run_clear(1'b0, 0, nwr, nbad, dc, nd, nres);
    for (int a = 0; a < 256; a++) ref_board[a] = 2'd0;
    exp_hits = 0;
    nz = 0;
    for (int a = 0; a < 144; a++) if (mem[{4'(a / 12), 4'(a % 12)}] !== 2'd0) nz++;
    n_cmp++; if (nwr != 144) begin n_fail++; $display("FAIL clear_writes: got %0d want 144", nwr); end
    n_cmp++; if (nbad != 0) begin n_fail++; $display("FAIL clear_order: %0d bad writes want 0", nbad); end
    n_cmp++; if (dc != 145 || nd != 1) begin
      n_fail++; $display("FAIL clear_done: cycle %0d count %0d want 145/1", dc, nd);
    end
    n_cmp++; if (nres != 0) begin n_fail++; $display("FAIL clear_ignores_shot: got %0d results want 0", nres); end
    n_cmp++; if (hit_count !== 8'd0 || shot_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_end_state: hc=%0d ready=%b want 0/1", hit_count, shot_ready);
    end
    n_cmp++; if (nz != 0) begin n_fail++; $display("FAIL clear_board: %0d nonzero cells want 0", nz); end
  endtask

  task automatic test_shot_hit;
    logic [1:0] code, wd, ec, ewd; logic [7:0] wa, ra1, hc; logic rdy1, sunk, rr;
    int lat, nres, nwr, el, ew;
    place(8'h35, 2'd1);
    model_shot(4'd3, 4'd5, ec, el, ew, ewd);
    fire(4'd3, 4'd5, code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
    n_cmp++; if (ra1 !== 8'h35) begin n_fail++; $display("FAIL hit_read_addr: got %h want 35", ra1); end
    n_cmp++; if (lat != 3 || nres != 1 || code !== 2'd1) begin
      n_fail++; $display("FAIL hit_result: lat %0d n %0d code %0d want 3/1/1", lat, nres, code);
    end
    n_cmp++; if (nwr != 1 || wa !== 8'h35 || wd !== 2'd3) begin
      n_fail++; $display("FAIL hit_write: n %0d addr %h data %0d want 1/35/3", nwr, wa, wd);
    end
    n_cmp++; if (hc !== 8'd1 || rr !== 1'b1) begin
      n_fail++; $display("FAIL hit_count: got %0d ready %b want 1/1", hc, rr);
    end
  endtask

  task automatic test_repeat_miss;
    logic [1:0] code, wd, ec, ewd; logic [7:0] wa, ra1, hc; logic rdy1, sunk, rr;
    int lat, nres, nwr, el, ew;
    model_shot(4'd3, 4'd5, ec, el, ew, ewd);
    fire(4'd3, 4'd5, code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
    n_cmp++; if (code !== 2'd2 || lat != 3 || nwr != 0) begin
      n_fail++; $display("FAIL repeat: code %0d lat %0d writes %0d want 2/3/0", code, lat, nwr);
    end
    model_shot(4'd0, 4'd0, ec, el, ew, ewd);
    fire(4'd0, 4'd0, code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
    n_cmp++; if (code !== 2'd0 || nwr != 1 || wa !== 8'h00 || wd !== 2'd2) begin
      n_fail++; $display("FAIL miss: code %0d n %0d addr %h data %0d want 0/1/00/2", code, nwr, wa, wd);
    end
  endtask

  task automatic test_invalid;
    logic [1:0] code, wd; logic [7:0] wa, ra1, hc, prev; logic rdy1, sunk, rr;
    int lat, nres, nwr;
    logic [3:0] xs [2];
    logic [3:0] ys [2];
    xs[0] = 4'd12; ys[0] = 4'd4; xs[1] = 4'd4; ys[1] = 4'd15;
    for (int k = 0; k < 2; k++) begin
      prev = mem_read_addr;
      fire(xs[k], ys[k], code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
      n_cmp++;
      if (code !== 2'd3 || lat != 1 || nres != 1 || nwr != 0 || ra1 !== prev || rdy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL invalid_%0d: code %0d lat %0d n %0d wr %0d ra %h rdy %b want 3/1/1/0/%h/1",
                 k, code, lat, nres, nwr, ra1, rdy1, prev);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] code, wd, ec, ewd; logic [7:0] wa, ra1, hc; logic rdy1, sunk, rr;
    logic [3:0] x, y;
    int lat, nres, nwr, el, ew, nbad;
    for (int k = 0; k < 30; k++) place({4'($urandom_range(11, 0)), 4'($urandom_range(11, 0))}, 2'd1);
    for (int k = 0; k < 40; k++) begin
      x = 4'($urandom_range(13, 0)); y = 4'($urandom_range(13, 0));
      model_shot(x, y, ec, el, ew, ewd);
      fire(x, y, code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
      n_cmp++; if (code !== ec || lat != el || nres != 1) begin
        n_fail++; $display("FAIL rnd_result(%0d,%0d): code %0d lat %0d want %0d/%0d", x, y, code, lat, ec, el);
      end
      n_cmp++; if (nwr != ew || (ew == 1 && (wa !== {x, y} || wd !== ewd))) begin
        n_fail++; $display("FAIL rnd_write(%0d,%0d): n %0d data %0d want %0d/%0d", x, y, nwr, wd, ew, ewd);
      end
      n_cmp++; if (hit_count !== 8'(exp_hits)) begin
        n_fail++; $display("FAIL rnd_hits: got %0d want %0d", hit_count, exp_hits);
      end
    end
    nbad = 0;
    for (int a = 0; a < 144; a++) if (mem[{4'(a / 12), 4'(a % 12)}] !== ref_board[{4'(a / 12), 4'(a % 12)}]) nbad++;
    n_cmp++; if (nbad != 0) begin n_fail++; $display("FAIL rnd_board: %0d cells differ want 0", nbad); end
  endtask

  task automatic test_all_sunk;
    logic [1:0] code, wd, ec, ewd; logic [7:0] wa, ra1, hc; logic rdy1, sunk, rr;
    logic [7:0] ships [20];
    logic [7:0] a;
    int lat, nres, nwr, el, ew, nbad, dc, nd;
    run_clear(1'b0, 0, nwr, nbad, dc, nd, nres);
    for (int i = 0; i < 256; i++) ref_board[i] = 2'd0;
    exp_hits = 0;
    for (int k = 0; k < 20; k++) begin
      do a = {4'($urandom_range(11, 0)), 4'($urandom_range(11, 0))}; while (ref_board[a] != 2'd0);
      ships[k] = a;
      place(a, 2'd1);
    end
    for (int k = 0; k < 20; k++) begin
      model_shot(ships[k][7:4], ships[k][3:0], ec, el, ew, ewd);
      fire(ships[k][7:4], ships[k][3:0], code, lat, nres, nwr, wa, wd, ra1, rdy1, hc, sunk, rr);
      n_cmp++; if (hc !== 8'(k + 1) || sunk !== (k == 19)) begin
        n_fail++; $display("FAIL sunk_%0d: hc %0d sunk %b want %0d/%b", k, hc, sunk, k + 1, k == 19);
      end
    end
    n_cmp++; if (all_sunk !== 1'b1) begin n_fail++; $display("FAIL sunk_hold: got %b want 1", all_sunk); end
    run_clear(1'b0, 0, nwr, nbad, dc, nd, nres);
    for (int i = 0; i < 256; i++) ref_board[i] = 2'd0;
    exp_hits = 0;
    n_cmp++; if (hit_count !== 8'd0 || all_sunk !== 1'b0) begin
      n_fail++; $display("FAIL sunk_clear: hc %0d sunk %b want 0/0", hit_count, all_sunk);
    end
  endtask

  task automatic test_clear_priority;
    int nwr, nbad, dc, nd, nres;
    run_clear(1'b1, 0, nwr, nbad, dc, nd, nres);
    n_cmp++; if (nwr != 144 || nbad != 0 || dc != 145 || nres != 0 || mem[8'h22] !== 2'd0) begin
      n_fail++; $display("FAIL clear_priority: wr %0d bad %0d done %0d res %0d want 144/0/145/0", nwr, nbad, dc, nres);
    end
  endtask

  task automatic test_reset_mid_clear;
    int nwr, nbad, dc, nd, nres, late, nz;
    for (int a = 0; a < 144; a++) place({4'(a / 12), 4'(a % 12)}, 2'd1);
    run_clear(1'b0, 50, nwr, nbad, dc, nd, nres);
    n_cmp++;
    if ({result_valid, result_code, clear_done, mem_write_enable, mem_write_addr, mem_write_data,
         mem_read_addr, hit_count, busy, all_sunk, shot_ready} !== {30'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_reset_values: ready=%b busy=%b wen=%b waddr=%h hc=%0d", shot_ready, busy,
               mem_write_enable, mem_write_addr, hit_count);
    end
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_write_enable) late++;
      @(posedge clk); #1;
    end
    nz = 0;
    for (int a = 0; a < 144; a++) if (mem[{4'(a / 12), 4'(a % 12)}] === 2'd0) nz++;
    n_cmp++; if (nwr != 50 || late != 0 || nz != 50 || dc != 0) begin
      n_fail++; $display("FAIL abort_writes: before %0d after %0d zeroed %0d done %0d want 50/0/50/0", nwr, late, nz, dc);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin mem[a] = 2'd0; ref_board[a] = 2'd0; end
    test_reset();
    test_clear();
    test_shot_hit();
    test_repeat_miss();
    test_invalid();
    test_random();
    test_all_sunk();
    test_clear_priority();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
